// File: rtl/demux1_to_4_tdm_pkg.sv
// Shared constants and helpers for the 4-slot TDM receive demultiplexer.
package demux1_to_4_tdm_pkg;

    localparam int NUM_SLOTS = 4;

    localparam logic [1:0] SLOT0 = 2'd0;
    localparam logic [1:0] SLOT1 = 2'd1;
    localparam logic [1:0] SLOT2 = 2'd2;
    localparam logic [1:0] SLOT3 = 2'd3;

    localparam logic [0:0] IDLE    = 1'b0;
    localparam logic [0:0] COLLECT = 1'b1;

    typedef struct packed {
        logic [3:0] wr_en;
        logic       complete;
        logic       seq_err;
    } slot_ctrl_t;

    function automatic logic [3:0] slot_onehot(input logic [1:0] slot);
        logic [3:0] oh;
        case (slot)
            SLOT0:   oh = 4'b0001;
            SLOT1:   oh = 4'b0010;
            SLOT2:   oh = 4'b0100;
            SLOT3:   oh = 4'b1000;
            default: oh = 4'b0000;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/demux1_to_4_tdm_slot_reg.sv
// One shadow register per slot: loads on write enable, cleared asynchronously.
module demux_slot_reg #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] data_r;

    // Shadow storage for one slot's lane data.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            data_r <= {WIDTH{1'b0}};
        end else if (wr_en) begin
            data_r <= d;
        end else begin
            data_r <= data_r;
        end
    end

    assign q = data_r;

endmodule

// File: rtl/demux1_to_4_tdm.sv
// Receive end of a 4-slot TDM link: collects one lane per slot and emits
// the assembled frame on a registered output with a one-cycle valid strobe.
module demux1_to_4_tdm
    import demux1_to_4_tdm_pkg::*;
#(
    parameter int WIDTH        = 1,
    parameter bit STRICT_ORDER = 1'b1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [WIDTH-1:0]   D,
    input  logic [1:0]         M,
    input  logic               in_valid,
    input  logic               flush,
    output logic [4*WIDTH-1:0] Q,
    output logic               q_valid,
    output logic               busy,
    output logic               seq_err
);

    logic [0:0]         state_r;
    logic [0:0]         state_nxt_s;
    logic [1:0]         exp_r;
    logic [1:0]         exp_nxt_s;
    logic [3:0]         mask_r;
    logic [3:0]         mask_nxt_s;
    logic [3:0]         onehot_s;
    logic               busy_nxt_s;
    slot_ctrl_t         ctrl_s;
    logic [4*WIDTH-1:0] frame_s;
    logic [WIDTH-1:0]   shadow_s [NUM_SLOTS];

    logic [4*WIDTH-1:0] q_r;
    logic               q_valid_r;
    logic               busy_r;
    logic               seq_err_r;

    assign onehot_s = slot_onehot(M);

    for (genvar k = 0; k < NUM_SLOTS; k++) begin : g_slot
        demux_slot_reg #(.WIDTH(WIDTH)) u_slot (
            .clk   (clk),
            .clr_n (reset_n),
            .wr_en (ctrl_s.wr_en[k]),
            .d     (D),
            .q     (shadow_s[k])
        );
    end

    // Per-cycle decision: which slot to write, frame completion, ordering errors.
    always_comb begin
        ctrl_s      = '{wr_en: 4'b0000, complete: 1'b0, seq_err: 1'b0};
        state_nxt_s = state_r;
        exp_nxt_s   = exp_r;
        mask_nxt_s  = mask_r;
        if (flush) begin
            state_nxt_s = IDLE;
            exp_nxt_s   = SLOT0;
            mask_nxt_s  = 4'b0000;
        end else if (in_valid) begin
            if (STRICT_ORDER == 1'b1) begin
                if (M == exp_r) begin
                    ctrl_s.wr_en = onehot_s;
                    if (M == SLOT3) begin
                        ctrl_s.complete = 1'b1;
                        exp_nxt_s       = SLOT0;
                        state_nxt_s     = IDLE;
                    end else begin
                        exp_nxt_s   = exp_r + 2'd1;
                        state_nxt_s = COLLECT;
                    end
                end else begin
                    // An out-of-order slot 0 is the most likely start of a fresh frame.
                    ctrl_s.seq_err = 1'b1;
                    if (M == SLOT0) begin
                        ctrl_s.wr_en = onehot_s;
                        exp_nxt_s    = SLOT1;
                        state_nxt_s  = COLLECT;
                    end else begin
                        exp_nxt_s   = SLOT0;
                        state_nxt_s = IDLE;
                    end
                end
            end else begin
                ctrl_s.wr_en = onehot_s;
                if ((mask_r | onehot_s) == 4'hF) begin
                    ctrl_s.complete = 1'b1;
                    mask_nxt_s      = 4'b0000;
                end else begin
                    mask_nxt_s = mask_r | onehot_s;
                end
            end
        end else begin
            state_nxt_s = state_r;
        end
    end

    // Frame image with the in-flight sample substituted at its own slot.
    always_comb begin
        frame_s = {(4*WIDTH){1'b0}};
        for (int k = 0; k < NUM_SLOTS; k++) begin
            if (onehot_s[k]) begin
                frame_s[k*WIDTH +: WIDTH] = D;
            end else begin
                frame_s[k*WIDTH +: WIDTH] = shadow_s[k];
            end
        end
    end

    // Busy reflects whether a partial frame survives this cycle's update.
    always_comb begin
        if (STRICT_ORDER == 1'b1) begin
            busy_nxt_s = (state_nxt_s == COLLECT);
        end else begin
            busy_nxt_s = (mask_nxt_s != 4'b0000);
        end
    end

    // Sequencing state: expected slot, FSM state and fill mask.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= IDLE;
            exp_r   <= SLOT0;
            mask_r  <= 4'b0000;
        end else begin
            state_r <= state_nxt_s;
            exp_r   <= exp_nxt_s;
            mask_r  <= mask_nxt_s;
        end
    end

    // Registered outputs; Q holds between frames.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q_r       <= {(4*WIDTH){1'b0}};
            q_valid_r <= 1'b0;
            busy_r    <= 1'b0;
            seq_err_r <= 1'b0;
        end else begin
            q_r       <= ctrl_s.complete ? frame_s : q_r;
            q_valid_r <= ctrl_s.complete;
            busy_r    <= busy_nxt_s;
            seq_err_r <= ctrl_s.seq_err;
        end
    end

    assign Q       = q_r;
    assign q_valid = q_valid_r;
    assign busy    = busy_r;
    assign seq_err = seq_err_r;

endmodule

// File: doc/demux1_to_4_tdm.md
Name: demux1_to_4_tdm

Overview:
- Time-division 1-to-4 demultiplexer: the receive end of a 4-slot select-and-forward link.
- Upstream, a 4-to-1 selector drives one data lane plus a 2-bit slot index `M`.
- This block captures each slot's data into a shadow register and assembles a 4-lane frame.
- When a frame completes, it presents the frame on a registered parallel output with a one-cycle valid strobe.
- It sits between the serial select path and the lab's parallel display/register logic.

Parameters:
- WIDTH, 1, width of each data lane (one lane per slot).
- STRICT_ORDER, 1, 1 = slots must arrive 0,1,2,3 in sequence; 0 = any order, frame completes when all four slots are filled.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- D  input  WIDTH  lane data for the current slot.
- M  input  2  slot index of D.
- in_valid  input  1  D/M valid this cycle.
- flush  input  1  synchronous discard of the partial frame.
- Q  output  4*WIDTH  assembled frame; slot k occupies Q[k*WIDTH +: WIDTH].
- q_valid  output  1  one-cycle pulse when Q is updated.
- busy  output  1  partial frame in progress (at least one slot captured).
- seq_err  output  1  one-cycle pulse on an out-of-order slot (STRICT_ORDER=1 only).

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - Outputs: Q=0, q_valid=0, busy=0, seq_err=0.
  - Internal state: shadow=0, fill mask=4'b0000, expected slot exp=0.
- All outputs are registered. Q and q_valid update on the clock edge after the cycle that completes a frame (latency 1).
- Q holds its value between frames. q_valid is high for exactly one cycle per frame.
- Priority per cycle: reset > flush > in_valid.
- Flush:
  - Clears the fill mask and sets exp=0.
  - A sample presented with in_valid in the same cycle is dropped.
  - Q is unchanged; no q_valid or seq_err pulse.
- STRICT_ORDER=1, FSM states IDLE (exp=0, mask empty) and COLLECT:
  - in_valid with M==exp: shadow[M]<=D, exp<=exp+1, state moves to COLLECT.
  - If M==3, the frame completes: Q<={D, shadow[2], shadow[1], shadow[0]}, q_valid=1, exp wraps to 0, state returns to IDLE.
  - in_valid with M!=exp: seq_err pulses and the partial frame is discarded.
    - If M==0: the sample is taken as the start of a new frame (shadow[0]<=D, exp<=1, COLLECT).
    - Otherwise: exp<=0, state IDLE, sample dropped.
  - busy = (state==COLLECT).
- STRICT_ORDER=0:
  - in_valid writes shadow[M]<=D and sets mask[M]. A repeated slot overwrites silently.
  - Completion occurs when (mask | onehot(M)) == 4'hF. Q is built from shadow with the current D substituted at slot M. Mask then clears.
  - seq_err is tied 0. busy = (mask != 0).
- in_valid low: no state change; q_valid and seq_err are 0.
- Back-to-back frames at one sample per cycle are supported: q_valid can fire every 4th cycle with no bubble.
- Reset mid-frame: partial data is lost, and Q returns to 0 immediately.

Decomposition:
- Shared package holds:
  - Slot constants SLOT0..SLOT3 = 2'd0..2'd3.
  - NUM_SLOTS = 4.
  - FSM state encoding IDLE=1'b0, COLLECT=1'b1.
- One sub-module, demux_slot_reg: a per-slot WIDTH-bit register with write enable and asynchronous active-low clear. It is instantiated four times; the top level holds the FSM/mask and the output register.

Test Plan:
- Reset: hold reset_n=0 with random D/M/in_valid -> Q=0, q_valid=0, busy=0, seq_err=0 throughout; exp=0 after release.
- Strict in-order frame, WIDTH=1: (M,D)=(0,1),(1,0),(2,1),(3,1) on consecutive cycles -> next cycle Q=4'b1101, q_valid=1 for exactly one cycle, busy=0.
- Strict out-of-order: (0,1),(2,1) -> seq_err pulses on the cycle after the second sample, busy=0. Then (0,0),(1,1),(2,1),(3,0) -> Q=4'b0110.
- Flush collision: (0,1),(1,1), then flush=1 with in_valid=1 and (2,1) in the same cycle -> no q_valid, busy=0, Q unchanged; a new full frame then completes normally.
- STRICT_ORDER=0, any order with overwrite: (3,1),(1,0),(1,1),(0,0),(2,0) -> Q=4'b1010, one q_valid pulse, seq_err never asserted.
- Streaming plus reset mid-frame:
  - 3 back-to-back strict frames -> q_valid on cycles 5, 9 and 13 after the first sample.
  - Then assert reset_n=0 after slot 1 of a 4th frame -> Q=0 asynchronously, no q_valid.
